nor_chain_tester: RTL and testbench

- Self-checking stimulus/response stage for the cascaded 4-input NOR chain block, which has inputs a, b, c, d and outputs e, f, g.
- Drives all 16 input combinations into the chain, waits a programmable settle time, samples e/f/g and compares them against a golden model.
- Reports an error count, the first failing vector and pass/fail.
- Sits directly upstream (drives a..d) and downstream (consumes e..g) of the NOR chain on the lab board.

---
 rtl/nor_chain_tester_if.sv | 13 +
 rtl/nor_chain_tester.sv | 139 +++++++++++++
 tb/tb_nor_chain_tester.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/nor_chain_tester_if.sv
// rtl/nor_chain_tester_if.sv - chain-side bus between the tester and the cascaded NOR chain
interface nor_chain_tester_if;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;

    modport master (output a, b, c, d, input e, f, g);
    modport slave  (input a, b, c, d, output e, f, g);
endinterface

// File: rtl/nor_chain_tester.sv
// rtl/nor_chain_tester.sv - 16-vector sweep and golden-model check of the NOR chain
// Optional: NOR_TEST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module nor_chain_tester #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    nor_chain_tester_if.master         chain,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [4:0]                 err_count_o,
    output logic [3:0]                 first_fail_vec_o,
    output logic                       first_fail_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic [3:0] ffv_q, ffv_d;
    logic       ffvalid_q, ffvalid_d;
    logic       pass_q, pass_d;

    logic ee, ef, eg;
    logic mismatch;
    logic last_vec;

    // Golden model is evaluated on the registered vector actually driven onto the chain.
    always_comb begin
        ee       = ~(vec_q[3] | vec_q[2]);
        ef       = ~(ee | vec_q[1]);
        eg       = ~(ef | vec_q[0]);
        mismatch = (chain.e != ee) | (chain.f != ef) | (chain.g != eg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vec_q     <= 4'd0;
            cnt_q     <= 4'd0;
            err_q     <= 5'd0;
            ffv_q     <= 4'd0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        pass_d    = pass_q;
        last_vec  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_DRIVE;
                    vec_d     = 4'd0;
                    cnt_d     = SETTLE_LOAD;
                    err_d     = 5'd0;
                    ffv_d     = 4'd0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
`ifdef NOR_TEST_STOP_ON_FAIL_EN
                last_vec = (vec_q == 4'hF) | mismatch;
`else
                last_vec = (vec_q == 4'hF);
`endif
                if (last_vec) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    state_d = S_DRIVE;
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o             = (state_q == S_DRIVE) | (state_q == S_SAMPLE);
        done_o             = (state_q == S_DONE);
        pass_o             = pass_q;
        err_count_o        = err_q;
        first_fail_vec_o   = ffv_q;
        first_fail_valid_o = ffvalid_q;
        chain.a            = vec_q[3];
        chain.b            = vec_q[2];
        chain.c            = vec_q[1];
        chain.d            = vec_q[0];
    end

endmodule

// File: tb/tb_nor_chain_tester.sv
// tb/tb_nor_chain_tester.sv - directed sweeps against a NOR chain model with injectable faults
module tb_nor_chain_tester;

    localparam int S = 1;
    localparam int SWEEP_CYC = 16 * (S + 1) + 1;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic       pass_o;
    logic [4:0] err_count_o;
    logic [3:0] first_fail_vec_o;
    logic       first_fail_valid_o;

    int errors = 0;
    int checks = 0;
    int fault  = 0;

    nor_chain_tester_if bus ();

    nor_chain_tester #(.SETTLE_CYCLES(S)) dut (
        .clk                (clk),
        .rst                (rst),
        .start_i            (start_i),
        .chain              (bus.master),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .pass_o             (pass_o),
        .err_count_o        (err_count_o),
        .first_fail_vec_o   (first_fail_vec_o),
        .first_fail_valid_o (first_fail_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: fault 1 = g stuck at 0, fault 2 = e stuck at 1 (f/g still correct).
    logic m_e, m_f, m_g;
    always_comb begin
        m_e   = ~(bus.a | bus.b);
        m_f   = ~(m_e | bus.c);
        m_g   = ~(m_f | bus.d);
        bus.e = (fault == 2) ? 1'b1 : m_e;
        bus.f = m_f;
        bus.g = (fault == 1) ? 1'b0 : m_g;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] abcd();
        return {bus.a, bus.b, bus.c, bus.d};
    endfunction

    task automatic run_sweep(input int extra_start_at, input int rst_at,
                             output int done_cyc, output int step_bad, output int pulses);
        int exp_vec;
        done_cyc = 0;
        step_bad = 0;
        pulses   = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            start_i = (cyc == extra_start_at);
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                return;
            end
            exp_vec = (cyc - 1) / (S + 1);
            if (busy_o && (abcd() != exp_vec[3:0])) step_bad++;
            if (done_o) begin
                pulses++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 3) break;
        end
        start_i = 1'b0;
    endtask

    int dc, sb, np;

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  busy_o, 0);
        check("rst_done",  done_o, 0);
        check("rst_pass",  pass_o, 0);
        check("rst_err",   err_count_o, 0);
        check("rst_ffv",   first_fail_vec_o, 0);
        check("rst_ffval", first_fail_valid_o, 0);
        check("rst_abcd",  abcd(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy_o, 0);

        // Healthy chain, extra start pulsed in the done cycle must be ignored.
        fault = 0;
        run_sweep(SWEEP_CYC, 0, dc, sb, np);
        check("ok_latency", dc, SWEEP_CYC);
        check("ok_pulses",  np, 1);
        check("ok_steps",   sb, 0);
        check("ok_err",     err_count_o, 0);
        check("ok_pass",    pass_o, 1);
        check("ok_ffval",   first_fail_valid_o, 0);
        check("ok_hold",    abcd(), 4'hF);
        check("ok_idle",    busy_o, 0);

        // g stuck at 0: golden g is 1 at vectors 0,2,6,10,14.
        fault = 1;
        run_sweep(0, 0, dc, sb, np);
`ifdef NOR_TEST_STOP_ON_FAIL_EN
        check("g0_latency", dc, 3);
        check("g0_err",     err_count_o, 1);
        check("g0_hold",    abcd(), 0);
`else
        check("g0_latency", dc, SWEEP_CYC);
        check("g0_err",     err_count_o, 5);
        check("g0_hold",    abcd(), 4'hF);
`endif
        check("g0_ffv",     first_fail_vec_o, 0);
        check("g0_ffval",   first_fail_valid_o, 1);
        check("g0_pass",    pass_o, 0);
        check("g0_steps",   sb, 0);

        // e stuck at 1: mismatches wherever a|b, i.e. vectors 4..15.
        fault = 2;
        run_sweep(0, 0, dc, sb, np);
`ifdef NOR_TEST_STOP_ON_FAIL_EN
        check("e1_latency", dc, 11);
        check("e1_err",     err_count_o, 1);
        check("e1_hold",    abcd(), 4);
`else
        check("e1_latency", dc, SWEEP_CYC);
        check("e1_err",     err_count_o, 12);
`endif
        check("e1_ffv",     first_fail_vec_o, 4);
        check("e1_ffval",   first_fail_valid_o, 1);
        check("e1_pass",    pass_o, 0);

        // Start re-pulsed mid-sweep is ignored; results from the new sweep clear old ones.
        fault = 0;
        run_sweep(10, 0, dc, sb, np);
        check("rs_latency", dc, SWEEP_CYC);
        check("rs_pulses",  np, 1);
        check("rs_steps",   sb, 0);
        check("rs_err",     err_count_o, 0);
        check("rs_pass",    pass_o, 1);
        check("rs_ffval",   first_fail_valid_o, 0);

        // Asynchronous reset in the middle of a faulty sweep.
        fault = 1;
        run_sweep(0, 15, dc, sb, np);
        check("ar_busy",  busy_o, 0);
        check("ar_abcd",  abcd(), 0);
        check("ar_err",   err_count_o, 0);
        check("ar_done",  done_o, 0);
        np = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o) np++;
        end
        check("ar_nodone", np, 0);
        rst   = 1'b0;
        fault = 0;
        run_sweep(0, 0, dc, sb, np);
        check("ar2_latency", dc, SWEEP_CYC);
        check("ar2_err",     err_count_o, 0);
        check("ar2_pass",    pass_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
